avr_io_uart_tx_arb: RTL and testbench
=====================================

Name: avr_io_uart_tx_arb

Overview:
Shares one avr_io_uart_tx transmitter between NREQ byte-stream requesters, for example CPU UDR writes, a debug monitor and a boot loader. Arbitration is round-robin at packet granularity. A granted requester keeps the transmitter until it marks a byte as last, or until it stalls past a timeout. A one-byte holding register feeds the transmitter's strobe/prefetch interface so that back-to-back bytes are sent with no idle bit between them.

Parameters:
NREQ, 3, number of requesters (2..4)
TIMEOUT, 255, idle cycles in LOCKED with no valid before the grant is forcibly released (1..255, 8-bit counter)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  arbitration enable; 0 = no new grants, the current packet completes
req_valid  in  NREQ  requester i has a byte
req_data  in  8*NREQ  byte of requester i, at bits [8i+7:8i]
req_last  in  NREQ  byte of requester i is the last of its packet
req_ready  out  NREQ  byte of requester i is accepted this cycle when valid & ready
grant  out  NREQ  one-hot current owner; all zero in IDLE
tx_data  out  8  to the transmitter tx_in (holding register)
tx_strobe  out  1  to the transmitter strobe (= hold_full)
tx_busy  in  1  from the transmitter busy
tx_prefetch  in  1  from the transmitter prefetch
timeout_evt  out  1  one-cycle pulse when a grant is released by timeout

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, grant=0, req_ready=0, hold_full=0, tx_data=0, tx_strobe=0, timeout_evt=0, last_grant=NREQ-1, timer=0.
  - A transmitter byte in flight is not aborted. The strobe simply drops, and the transmitter finishes that byte and returns to idle.
- Holding register:
  - consume = (hold_full & ~tx_busy) | tx_prefetch.
  - When consume is true, hold_full clears at the next edge.
  - A load and a consume never coincide, because req_ready requires ~hold_full.
- FSM states: IDLE, LOCKED.
- IDLE:
  - If en=1 and any req_valid is set, pick the first valid index searching last_grant+1, last_grant+2, … modulo NREQ.
  - The picked index is latched into grant (one-hot), and the FSM moves to LOCKED at the next edge.
  - req_ready is 0 in IDLE, so the first byte of a packet has 1 cycle of grant latency.
- LOCKED with owner g:
  - req_ready[g] = ~hold_full; all other ready bits are 0. req_ready is combinational from registered state only, with no path from req_valid.
  - On accept (valid[g] & ready[g]): tx_data<=req_data[g], hold_full<=1, timer<=0.
  - If req_last[g] is also set on that accept: state<=IDLE, last_grant<=g, grant<=0.
  - If valid[g]=0: timer increments. When timer==TIMEOUT-1 at the edge, the FSM moves to IDLE, last_grant<=g, grant<=0, and timeout_evt pulses 1 cycle.
  - Timer is held at 0 while valid[g]=1 and hold_full=1 (a backpressure stall is not a timeout).
- en=0 in LOCKED has no effect on the current packet. en=0 in IDLE blocks new grants.
- End-to-end latency: valid asserted at cycle 0 in IDLE → grant at cycle 1 → accept at cycle 1 → tx_strobe high at cycle 2 → tx_busy high at cycle 3.
- Back-to-back:
  - The next byte loads while the transmitter shifts.
  - tx_prefetch at the stop bit consumes it, and the new start bit follows the stop bit directly.
- Re-grant to the same requester is allowed only when no other requester is valid.
- Owner rotation: the next owner can be chosen in the cycle after release, while the previous packet's final byte still sits in the holding register. That byte is sent first, so the byte order on the line is preserved.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, LOCKED=1) and the timer width constant (8).
- One natural sub-module, avr_io_uart_rr_pick: combinational round-robin priority selector with inputs req[NREQ] and last[NREQ], and output one-hot pick. It is reused by future IRQ/DMA arbiters.

Test Plan:
1. Single packet:
   - Stimulus: req0 sends 0x55, 0xA3(last) with prescaler 3; tx model attached.
   - Required: txd shows start/0x55/stop then start/0xA3/stop with no idle bit between; grant returns to 0 one edge after 0xA3 is accepted.
2. Round-robin:
   - Stimulus: req0, req1 and req2 all valid, each with 1-byte packets 0x10, 0x20, 0x30, repeated twice.
   - Required: line order 0x10, 0x20, 0x30, 0x10, 0x20, 0x30.
3. Packet lock:
   - Stimulus: req1 sends a 3-byte packet 0x01, 0x02, 0x03(last) while req0 is continuously valid with 0xFF.
   - Required: 0xFF appears only after 0x03; req_ready[0]=0 throughout.
4. Timeout:
   - Stimulus: TIMEOUT=8; req2 sends 1 byte with no last, then drops valid.
   - Required: timeout_evt pulses exactly 8 cycles after the accept; pending req0 is granted on the next cycle.
5. Reset mid-byte:
   - Stimulus: assert rst low while the holding register is full and the transmitter is mid-byte.
   - Required: grant, req_ready and tx_strobe are 0 immediately (asynchronously); the held byte is never transmitted; the transmitter returns to idle after its current byte.
6. Enable gating:
   - Stimulus: en=0 with req0 valid.
   - Required: grant stays 0 for 50 cycles; setting en=1 produces a grant on the next edge. Dropping en mid-packet still completes the packet.

Source files
------------

// File: rtl/avr_io_uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter and its round-robin picker.
package avr_io_uart_tx_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int TIMER_W = 8;

endpackage

// File: rtl/avr_io_uart_tx_arb_if.sv
// Requester byte streams plus the strobe/prefetch link to the shared transmitter.
interface avr_io_uart_tx_arb_if #(parameter int NREQ = 3);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][7:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      grant;
  logic [7:0]           tx_data;
  logic                 tx_strobe;
  logic                 tx_busy;
  logic                 tx_prefetch;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy, tx_prefetch,
    output req_ready, grant, tx_data, tx_strobe
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy, tx_prefetch,
    input  req_ready, grant, tx_data, tx_strobe
  );
endinterface

// File: rtl/avr_io_uart_rr_pick.sv
// Combinational round-robin selector: first set req after the one-hot 'last'
// position, wrapping modulo NREQ; 'last' itself has lowest priority.
module avr_io_uart_rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last,
  output logic [NREQ-1:0] pick
);

  always_comb begin
    int  base;
    int  idx;
    logic found;
    pick  = '0;
    base  = 0;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (last[i]) base = i;
    end
    for (int k = 1; k <= NREQ; k++) begin
      idx = (base + k) % NREQ;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avr_io_uart_tx_arb.sv
// Packet-granular round-robin sharing of one UART transmitter, with a one-byte
// holding register so consecutive bytes leave with no idle bit between them.
module avr_io_uart_tx_arb
  import avr_io_uart_tx_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  avr_io_uart_tx_arb_if.slave  bus,
  output logic                 timeout_evt
);

  localparam logic [TIMER_W-1:0] TMAX     = TIMER_W'(TIMEOUT - 1);
  localparam logic [NREQ-1:0]    LAST_RST = NREQ'(1) << (NREQ - 1);

  arb_state_e         state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [NREQ-1:0]    last_q, last_d;
  logic               hold_full_q, hold_full_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               tevt_q, tevt_d;

  logic [NREQ-1:0] pick, ready;
  logic [7:0]      own_data;
  logic            own_valid, own_last, accept, consume;

  avr_io_uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (bus.req_valid),
    .last (last_q),
    .pick (pick)
  );

  // Ready depends only on registered state, never on req_valid.
  assign ready     = (state_q == ST_LOCKED && !hold_full_q) ? grant_q : '0;
  assign accept    = |(bus.req_valid & ready);
  assign own_valid = |(bus.req_valid & grant_q);
  assign own_last  = |(bus.req_last & grant_q);
  assign consume   = (hold_full_q & ~bus.tx_busy) | bus.tx_prefetch;

  always_comb begin
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) own_data = bus.req_data[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    hold_full_d = hold_full_q & ~consume;
    tx_data_d   = tx_data_q;
    timer_d     = timer_q;
    tevt_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && |bus.req_valid) begin
          grant_d = pick;
          state_d = ST_LOCKED;
          timer_d = '0;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          tx_data_d   = own_data;
          hold_full_d = 1'b1;
          timer_d     = '0;
          if (own_last) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
            grant_d = '0;
          end
        end else if (!own_valid) begin
          if (timer_q == TMAX) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
            grant_d = '0;
            timer_d = '0;
            tevt_d  = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end else begin
          // owner is valid but blocked by a full holding register
          timer_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= LAST_RST;
      hold_full_q <= 1'b0;
      tx_data_q   <= '0;
      timer_q     <= '0;
      tevt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      hold_full_q <= hold_full_d;
      tx_data_q   <= tx_data_d;
      timer_q     <= timer_d;
      tevt_q      <= tevt_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.grant     = grant_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_strobe = hold_full_q;
  assign timeout_evt   = tevt_q;

endmodule

// File: tb/tb_avr_io_uart_tx_arb.sv
// Bench for the UART transmit arbiter: behavioural transmitter, per-requester
// byte queues, and a packet-level round-robin model for the expected line order.
module tb_avr_io_uart_tx_arb;
  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic timeout_evt;

  avr_io_uart_tx_arb_if #(.NREQ(NREQ)) bus ();

  avr_io_uart_tx_arb #(.NREQ(NREQ), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bus         (bus),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  // transmitter model: start + 8 data + stop, each presc cycles
  int   presc = 3;
  logic tx_busy = 1'b0;
  int   pcnt = 0, bcnt = 0;
  logic tx_prefetch;
  logic [7:0] line_q[$];
  bit         cont_q[$];

  assign tx_prefetch     = tx_busy && bcnt == 9 && pcnt == presc - 1;
  assign bus.tx_busy     = tx_busy;
  assign bus.tx_prefetch = tx_prefetch;

  always @(posedge clk) begin
    if (!tx_busy) begin
      if (bus.tx_strobe) begin
        tx_busy <= 1'b1; pcnt <= 0; bcnt <= 0;
        line_q.push_back(bus.tx_data); cont_q.push_back(1'b0);
      end
    end else if (pcnt == presc - 1) begin
      pcnt <= 0;
      if (bcnt == 9) begin
        if (bus.tx_strobe) begin
          bcnt <= 0;
          line_q.push_back(bus.tx_data); cont_q.push_back(1'b1);
        end else tx_busy <= 1'b0;
      end else bcnt <= bcnt + 1;
    end else pcnt <= pcnt + 1;
  end

  logic [7:0] qd[NREQ][$];
  bit         ql[NREQ][$];
  int         gap[NREQ];
  bit         gap_en = 1'b0;
  logic [7:0] exp_q[$];
  int n_chk = 0, n_fail = 0;
  int cyc_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input int r, input logic [7:0] d, input bit l);
    qd[r].push_back(d); ql[r].push_back(l);
  endtask

  task automatic ex(input logic [7:0] d);
    exp_q.push_back(d);
  endtask

  // one clock: drive at negedge, record accepts before the edge, check after it
  task automatic cyc();
    logic [NREQ-1:0] acc, lacc;
    bit v;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      v = qd[i].size() != 0 && gap[i] == 0;
      bus.req_valid[i] = v;
      bus.req_data[i]  = v ? qd[i][0] : 8'($urandom);
      bus.req_last[i]  = v ? ql[i][0] : 1'($urandom);
    end
    #1;
    chk("ready_in_grant", 32'(bus.req_ready & ~bus.grant), 0);
    chk("grant_onehot0", 32'($onehot0(bus.grant)), 1);
    chk("ready_when_full", 32'(bus.tx_strobe && |bus.req_ready), 0);
    acc  = bus.req_valid & bus.req_ready;
    lacc = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        lacc[i] = ql[i][0];
        void'(qd[i].pop_front()); void'(ql[i].pop_front());
        if (!lacc[i] && gap_en && $urandom_range(0, 3) == 0) gap[i] = $urandom_range(1, 3);
      end else if (gap[i] > 0) gap[i]--;
    end
    @(posedge clk);
    cyc_n++;
    #1;
    if (|lacc) chk("grant_release", 32'(bus.grant), 0);
  endtask

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      cyc();
      done = qd[0].size() == 0 && qd[1].size() == 0 && qd[2].size() == 0 &&
             !tx_busy && !bus.tx_strobe;
    end
    chk({tag, "_done"}, 32'(done), 1);
  endtask

  task automatic check_line(input string tag, input bit want_cont);
    chk({tag, "_len"}, line_q.size(), exp_q.size());
    for (int i = 0; i < line_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), 32'(line_q[i]), 32'(exp_q[i]));
      if (want_cont && i > 0) chk($sformatf("%s_cont%0d", tag, i), 32'(cont_q[i]), 1);
    end
    line_q.delete(); cont_q.delete(); exp_q.delete();
  endtask

  task automatic clear_q();
    for (int i = 0; i < NREQ; i++) begin
      qd[i].delete(); ql[i].delete(); gap[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_q();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    line_q.delete(); cont_q.delete();
  endtask

  // packet-level reference: every requester with work stays valid, so packets
  // leave in round-robin order starting after the last owner
  task automatic build_exp();
    logic [7:0] md[NREQ][$];
    bit         ml[NREQ][$];
    int  ptr, idx;
    bit  l;
    for (int i = 0; i < NREQ; i++) begin md[i] = qd[i]; ml[i] = ql[i]; end
    ptr = NREQ - 1;
    exp_q.delete();
    forever begin
      idx = -1;
      for (int k = 1; k <= NREQ; k++)
        if (idx < 0 && md[(ptr + k) % NREQ].size() != 0) idx = (ptr + k) % NREQ;
      if (idx < 0) break;
      l = 1'b0;
      while (!l && md[idx].size() != 0) begin
        exp_q.push_back(md[idx].pop_front());
        l = ml[idx].pop_front();
      end
      ptr = idx;
    end
  endtask

  initial begin
    int acc_c, evt_c, n_evt, s;
    bit hit;
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
    clear_q();
    en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_strobe", 32'(bus.tx_strobe), 0);
    chk("rst_txdata", 32'(bus.tx_data), 0);
    chk("rst_tevt", 32'(timeout_evt), 0);
    @(negedge clk); rst = 1'b1;

    // single packet with latency checks
    put(0, 8'h55, 0); put(0, 8'hA3, 1);
    cyc(); chk("t1_grant", 32'(bus.grant), 1); chk("t1_ready", 32'(bus.req_ready), 1);
    cyc(); chk("t1_strobe", 32'(bus.tx_strobe), 1);
    cyc(); chk("t1_busy", 32'(tx_busy), 1);
    drain("t1", 500);
    ex(8'h55); ex(8'hA3);
    check_line("t1", 1'b1);

    // round robin from reset
    do_reset();
    for (int r = 0; r < 2; r++) begin put(0, 8'h10, 1); put(1, 8'h20, 1); put(2, 8'h30, 1); end
    drain("t2", 2000);
    ex(8'h10); ex(8'h20); ex(8'h30); ex(8'h10); ex(8'h20); ex(8'h30);
    check_line("t2", 1'b0);

    // packet lock: req0 waits for req1's whole packet
    put(1, 8'h01, 0); put(1, 8'h02, 0); put(1, 8'h03, 1);
    cyc(); chk("t3_grant", 32'(bus.grant), 3'b010);
    put(0, 8'hFF, 1);
    for (int k = 0; k < 500 && qd[1].size() != 0; k++) begin
      cyc(); chk("t3_ready0", 32'(bus.req_ready[0]), 0);
    end
    drain("t3", 1000);
    ex(8'h01); ex(8'h02); ex(8'h03); ex(8'hFF);
    check_line("t3", 1'b0);

    // timeout: req2 stops mid-packet, req0 pending
    put(2, 8'hB2, 0);
    cyc(); chk("t4_grant", 32'(bus.grant), 3'b100);
    put(0, 8'h77, 1);
    acc_c = -1000; evt_c = -100; n_evt = 0;
    for (int k = 0; k < 40; k++) begin
      s = qd[2].size();
      cyc();
      if (s == 1 && qd[2].size() == 0) acc_c = cyc_n;
      if (timeout_evt) begin n_evt++; evt_c = cyc_n; end
      if (cyc_n == evt_c + 1) chk("t4_regrant", 32'(bus.grant), 3'b001);
    end
    chk("t4_delay", 32'(evt_c - acc_c), 8);
    chk("t4_pulses", 32'(n_evt), 1);
    drain("t4", 1000);
    ex(8'hB2); ex(8'h77);
    check_line("t4", 1'b0);

    // reset while a byte is held and another is on the line
    put(0, 8'hA1, 0); put(0, 8'hA2, 0); put(0, 8'hA3, 1);
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      cyc();
      hit = bus.tx_strobe && tx_busy;
    end
    chk("t5_reach", 32'(hit), 1);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("t5_grant", 32'(bus.grant), 0);
    chk("t5_ready", 32'(bus.req_ready), 0);
    chk("t5_strobe", 32'(bus.tx_strobe), 0);
    clear_q();
    repeat (4) cyc();
    @(negedge clk); rst = 1'b1;
    drain("t5", 1000);
    chk("t5_idle", 32'(tx_busy), 0);
    ex(8'hA1);
    check_line("t5", 1'b0);

    // enable gating
    en = 1'b0;
    put(0, 8'hC1, 0); put(0, 8'hC2, 1);
    for (int k = 0; k < 50; k++) begin cyc(); chk("t6_nogrant", 32'(bus.grant), 0); end
    en = 1'b1;
    cyc(); chk("t6_grant", 32'(bus.grant), 1);
    cyc();
    en = 1'b0;
    drain("t6", 1000);
    en = 1'b1;
    ex(8'hC1); ex(8'hC2);
    check_line("t6", 1'b0);

    // randomized packets, requester stalls and line speeds
    for (int r = 0; r < 8; r++) begin
      do_reset();
      presc  = $urandom_range(1, 4);
      gap_en = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        int npk, len;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) put(i, 8'($urandom), b == len - 1);
        end
      end
      build_exp();
      drain($sformatf("rnd%0d", r), 5000);
      check_line($sformatf("rnd%0d", r), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
